// File: rtl/max_abs_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : max_abs_scan_ctrl_if
// Description : Bus bundle between max_abs_scan_ctrl and the memories.
//               Carries the valid-qualified vector read port and the result
//               write port.
//               master : the sequencer (issues reads, writes results)
//               slave  : the memory side (returns read data)
// Signals     : mem_rd_en     1       read request, one cycle
//               mem_addr      ADDR_W  read address
//               mem_rd_data   12      packed vector {w3, w2, w1}
//               mem_rd_valid  1       read data valid
//               res_wr_en     1       result write strobe, one cycle
//               res_addr      ADDR_W  result write address
//               res_data      4       result write data
// Revision    : 1.0 - initial release
// ============================================================================
interface max_abs_scan_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [11:0]       mem_rd_data;
    logic              mem_rd_valid;
    logic              res_wr_en;
    logic [ADDR_W-1:0] res_addr;
    logic [3:0]        res_data;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        input  mem_rd_valid,
        output res_wr_en,
        output res_addr,
        output res_data
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        output mem_rd_valid,
        input  res_wr_en,
        input  res_addr,
        input  res_data
    );
endinterface
`default_nettype wire

// File: rtl/max_abs_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : max_abs_scan_ctrl
// Description : Batch sequencer for the maxAbsValueCir datapath. For each of
//               count vectors it reads a packed 12-bit word, drives the three
//               4-bit operands, captures the datapath result, writes it to the
//               result memory and tracks the batch peak (unsigned max).
// Optional    : define MAXABS_CTRL_TIMEOUT_EN to abort a batch (err=1) when
//               read data does not arrive within TIMEOUT cycles.
// Ports       : clk           clock, rising edge
//               global_reset  synchronous active-high reset
//               start         begin a batch (accepted only when idle)
//               vec_base      first vector address
//               res_base      first result address
//               count         number of vectors (0 legal)
//               bus           max_abs_scan_ctrl_if.master (read/write ports)
//               dp_w1..dp_w3  registered datapath operands
//               dp_out        datapath result (combinational from dp_w*)
//               peak          largest result of the current batch
//               busy          batch in progress
//               done          one-cycle end-of-batch pulse
//               err           read timeout flag (0 without the macro)
// Revision    : 1.0 - initial release
// ============================================================================
module max_abs_scan_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                global_reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   vec_base,
    input  logic [ADDR_W-1:0]   res_base,
    input  logic [ADDR_W-1:0]   count,
    max_abs_scan_ctrl_if.master bus,
    output logic [3:0]          dp_w1,
    output logic [3:0]          dp_w2,
    output logic [3:0]          dp_w3,
    input  logic [3:0]          dp_out,
    output logic [3:0]          peak,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_exec  = 3'd3;
    localparam logic [2:0] c_st_write = 3'd4;
    localparam logic [2:0] c_st_fin   = 3'd5;

    localparam logic [ADDR_W-1:0] c_one  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] c_zero = '0;

    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_vec_base;
    logic [ADDR_W-1:0] r_res_base;
    logic [ADDR_W-1:0] r_count;
    logic [ADDR_W-1:0] r_idx;
    logic [3:0]        r_dp_w1;
    logic [3:0]        r_dp_w2;
    logic [3:0]        r_dp_w3;
    logic [3:0]        r_res_data;
    logic [3:0]        r_peak;
    logic              r_busy;
    logic              r_done;

    logic [ADDR_W-1:0] w_idx_next;

`ifdef MAXABS_CTRL_TIMEOUT_EN
    localparam int              c_wait_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(TIMEOUT - 1);
    logic [c_wait_w-1:0] r_wait_cnt;
    logic                r_err;
`endif

    assign w_idx_next = r_idx + c_one;

    always_ff @(posedge clk) begin
        if (global_reset) begin
            r_state    <= c_st_idle;
            r_vec_base <= '0;
            r_res_base <= '0;
            r_count    <= '0;
            r_idx      <= '0;
            r_dp_w1    <= '0;
            r_dp_w2    <= '0;
            r_dp_w3    <= '0;
            r_res_data <= '0;
            r_peak     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef MAXABS_CTRL_TIMEOUT_EN
            r_wait_cnt <= '0;
            r_err      <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_vec_base <= vec_base;
                        r_res_base <= res_base;
                        r_count    <= count;
                        r_idx      <= '0;
                        r_peak     <= '0;
                        r_busy     <= 1'b1;
`ifdef MAXABS_CTRL_TIMEOUT_EN
                        r_err      <= 1'b0;
`endif
                        r_state    <= (count == c_zero) ? c_st_fin : c_st_fetch;
                    end
                end
                c_st_fetch: begin
`ifdef MAXABS_CTRL_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    r_state <= c_st_wait;
                end
                c_st_wait: begin
                    if (bus.mem_rd_valid) begin
                        r_dp_w1 <= bus.mem_rd_data[3:0];
                        r_dp_w2 <= bus.mem_rd_data[7:4];
                        r_dp_w3 <= bus.mem_rd_data[11:8];
                        r_state <= c_st_exec;
                    end
`ifdef MAXABS_CTRL_TIMEOUT_EN
                    // Abort after TIMEOUT silent cycles; the write is skipped.
                    else if (r_wait_cnt == c_wait_last) begin
                        r_err   <= 1'b1;
                        r_state <= c_st_fin;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
`endif
                end
                c_st_exec: begin
                    // Operands were registered last cycle, so dp_out is settled.
                    r_res_data <= dp_out;
                    if (dp_out > r_peak) begin
                        r_peak <= dp_out;
                    end
                    r_state <= c_st_write;
                end
                c_st_write: begin
                    r_idx   <= w_idx_next;
                    r_state <= (w_idx_next == r_count) ? c_st_fin : c_st_fetch;
                end
                c_st_fin: begin
                    // done is registered here so it appears as busy falls.
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Strobes decode directly from the state register, so each lasts exactly
    // one cycle and the two can never overlap.
    assign bus.mem_rd_en = (r_state == c_st_fetch);
    assign bus.mem_addr  = r_vec_base + r_idx;
    assign bus.res_wr_en = (r_state == c_st_write);
    assign bus.res_addr  = r_res_base + r_idx;
    assign bus.res_data  = r_res_data;

    assign dp_w1 = r_dp_w1;
    assign dp_w2 = r_dp_w2;
    assign dp_w3 = r_dp_w3;
    assign peak  = r_peak;
    assign busy  = r_busy;
    assign done  = r_done;

`ifdef MAXABS_CTRL_TIMEOUT_EN
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_max_abs_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_max_abs_scan_ctrl
// Description : Self-checking bench for max_abs_scan_ctrl. A behavioural
//               memory with programmable read latency feeds the controller,
//               a behavioural maxAbsValueCir closes the datapath loop, and a
//               per-batch reference list of reads, writes, peak and done
//               latency is derived from the vector memory contents.
//               Honours MAXABS_CTRL_TIMEOUT_EN for the timeout scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_max_abs_scan_ctrl;

    localparam int ADDR_W  = 8;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        global_reset;
    logic        start;
    logic [7:0]  vec_base;
    logic [7:0]  res_base;
    logic [7:0]  count;
    logic [3:0]  dp_w1;
    logic [3:0]  dp_w2;
    logic [3:0]  dp_w3;
    logic [3:0]  dp_out;
    logic [3:0]  peak;
    logic        busy;
    logic        done;
    logic        err;

    max_abs_scan_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    max_abs_scan_ctrl #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk          (clk),
        .global_reset (global_reset),
        .start        (start),
        .vec_base     (vec_base),
        .res_base     (res_base),
        .count        (count),
        .bus          (bus),
        .dp_w1        (dp_w1),
        .dp_w2        (dp_w2),
        .dp_w3        (dp_w3),
        .dp_out       (dp_out),
        .peak         (peak),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_vec  = 0;
    int n_bad  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [11:0] mem [256];
    int          g_lat  = 1;
    bit          g_spur = 1'b0;
    bit          g_drop = 1'b0;

    // Largest magnitude of the three signed 4-bit fields; -8 gives 8.
    function automatic logic [3:0] f_max_abs(input logic [11:0] word);
        int m;
        m = 0;
        for (int k = 0; k < 3; k++) begin
            logic signed [3:0] s;
            int v;
            s = word[4*k +: 4];
            v = s;
            if (v < 0) v = -v;
            if (v > m) m = v;
        end
        return m[3:0];
    endfunction

    always_comb dp_out = f_max_abs({dp_w3, dp_w2, dp_w1});

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Memory model: data returns L cycles after the request is seen; optional
    // spurious valids are injected whenever no read is outstanding.
    initial begin
        int         pend;
        logic [7:0] paddr;
        pend  = 0;
        paddr = '0;
        bus.mem_rd_valid = 1'b0;
        bus.mem_rd_data  = '0;
        forever begin
            @(negedge clk);
            bus.mem_rd_valid = 1'b0;
            bus.mem_rd_data  = 12'($urandom);
            if (global_reset) begin
                pend = 0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        bus.mem_rd_valid = 1'b1;
                        bus.mem_rd_data  = mem[paddr];
                    end
                end else if (!bus.mem_rd_en && g_spur && $urandom_range(3) == 0) begin
                    bus.mem_rd_valid = 1'b1;
                end
                if (bus.mem_rd_en && !g_drop) begin
                    pend  = g_lat;
                    paddr = bus.mem_addr;
                end
            end
        end
    end

    task automatic run_batch(input logic [7:0] vb, input logic [7:0] rb, input logic [7:0] cnt,
                             input int lat, input bit spur, input bit poke);
        logic [7:0]  exp_rd [$];
        logic [7:0]  exp_wa [$];
        logic [3:0]  exp_wd [$];
        logic [3:0]  exp_peak;
        logic [11:0] last;
        logic [7:0]  a;
        int          exp_lat;
        int          t0;
        int          k;
        exp_peak = '0;
        last     = '0;
        for (int i = 0; i < int'(cnt); i++) begin
            a = vb + 8'(i);
            exp_rd.push_back(a);
            exp_wa.push_back(rb + 8'(i));
            exp_wd.push_back(f_max_abs(mem[a]));
            if (f_max_abs(mem[a]) > exp_peak) exp_peak = f_max_abs(mem[a]);
            last = mem[a];
        end
        exp_lat = (3 + lat) * int'(cnt) + 2;
        g_lat  = lat;
        g_spur = spur;
        g_drop = 1'b0;

        @(negedge clk);
        start    = 1'b1;
        vec_base = vb;
        res_base = rb;
        count    = cnt;
        t0       = cyc + 1;
        forever begin
            @(negedge clk);
            k = cyc - t0;
            if (k == 0) begin
                start = 1'b0;
                chk("busy_rise", busy, 1'b1);
            end
            if (poke && k == 3) begin
                start    = 1'b1;
                vec_base = vb + 8'd7;
                count    = cnt + 8'd3;
            end
            if (poke && k == 4) start = 1'b0;
            if (bus.mem_rd_en || bus.res_wr_en)
                chk("rd_wr_excl", bus.mem_rd_en & bus.res_wr_en, 1'b0);
            if (bus.mem_rd_en) begin
                if (exp_rd.size() == 0) chk("rd_extra", 1'b1, 1'b0);
                else chk("rd_addr", bus.mem_addr, exp_rd.pop_front());
            end
            if (bus.res_wr_en) begin
                if (exp_wa.size() == 0) chk("wr_extra", 1'b1, 1'b0);
                else begin
                    chk("wr_addr", bus.res_addr, exp_wa.pop_front());
                    chk("wr_data", bus.res_data, exp_wd.pop_front());
                end
            end
            if (done) begin
                chk("done_latency", k + 1, exp_lat);
                break;
            end
            if (k > exp_lat + 20) begin
                chk("done_timeout", 1'b0, 1'b1);
                break;
            end
        end
        chk("rd_missing", exp_rd.size(), 0);
        chk("wr_missing", exp_wa.size(), 0);
        chk("peak", peak, exp_peak);
        chk("busy_fall", busy, 1'b0);
        chk("err_clear", err, 1'b0);
        if (cnt != 0) begin
            chk("last_w1", dp_w1, last[3:0]);
            chk("last_w2", dp_w2, last[7:4]);
            chk("last_w3", dp_w3, last[11:8]);
            chk("last_res", bus.res_data, f_max_abs(last));
        end
        @(negedge clk);
        chk("done_pulse", done, 1'b0);
        chk("peak_hold", peak, exp_peak);
    endtask

    task automatic chk_all_zero(input string tag);
        logic [63:0] all;
        all = {bus.mem_rd_en, bus.mem_addr, bus.res_wr_en, bus.res_addr, bus.res_data,
               dp_w1, dp_w2, dp_w3, peak, busy, done, err};
        chk(tag, all[31:0], 32'h0);
        chk({tag, "_hi"}, all[63:32], 32'h0);
    endtask

    initial begin
        int nrd;
        int nwr;
        int nbusy_lo;
        int ndone;
        global_reset = 1'b1;
        start        = 1'b0;
        vec_base     = '0;
        res_base     = '0;
        count        = '0;
        for (int i = 0; i < 256; i++) mem[i] = 12'($urandom);
        mem[8'h10] = 12'h3F2;

        // Reset held two cycles.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset_outputs");
        global_reset = 1'b0;

        // Empty batch, then the single-vector case.
        run_batch(8'h00, 8'h00, 8'd0, 1, 1'b0, 1'b0);
        run_batch(8'h10, 8'h80, 8'd1, 1, 1'b0, 1'b0);
        chk("sv_w1", dp_w1, 4'h2);
        chk("sv_w2", dp_w2, 4'hF);
        chk("sv_w3", dp_w3, 4'h3);
        chk("sv_res", bus.res_data, 4'h3);

        // Address wrap with latency 3, spurious valids and a start while busy.
        run_batch(8'hFE, 8'hFE, 8'd4, 3, 1'b1, 1'b1);

        // Mid-batch reset during the second WAIT.
        g_lat = 2; g_spur = 1'b0; g_drop = 1'b0;
        nrd = 0; nwr = 0;
        @(negedge clk);
        start = 1'b1; vec_base = 8'h40; res_base = 8'h50; count = 8'd4;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 40 && nrd < 2; i++) begin
            if (bus.mem_rd_en) nrd++;
            if (bus.res_wr_en) nwr++;
            if (nrd < 2) @(negedge clk);
        end
        @(negedge clk);
        global_reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset_outputs");
        chk("midreset_writes_before", nwr, 1);
        global_reset = 1'b0;
        nrd = 0; nwr = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.mem_rd_en) nrd++;
            if (bus.res_wr_en) nwr++;
        end
        chk("midreset_no_rd", nrd, 0);
        chk("midreset_no_wr", nwr, 0);

        // Read data withheld.
        g_drop = 1'b1; g_spur = 1'b0;
        nwr = 0; ndone = 0; nbusy_lo = 0;
        @(negedge clk);
        start = 1'b1; vec_base = 8'h20; res_base = 8'h60; count = 8'd2;
`ifdef MAXABS_CTRL_TIMEOUT_EN
        begin
            int t0;
            int lat;
            t0  = cyc + 1;
            lat = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (bus.res_wr_en) nwr++;
                if (done) begin
                    lat = cyc - t0 + 1;
                    break;
                end
            end
            chk("to_latency", lat, TIMEOUT + 3);
            chk("to_err", err, 1'b1);
            chk("to_no_wr", nwr, 0);
            @(negedge clk);
            chk("to_err_hold", err, 1'b1);
            chk("to_busy", busy, 1'b0);
        end
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) nbusy_lo++;
            if (done) ndone++;
            if (bus.res_wr_en) nwr++;
        end
        chk("stall_busy", nbusy_lo, 0);
        chk("stall_no_done", ndone, 0);
        chk("stall_no_wr", nwr, 0);
        chk("stall_err", err, 1'b0);
        global_reset = 1'b1;
        repeat (2) @(negedge clk);
        global_reset = 1'b0;
`endif
        g_drop = 1'b0;

        // Randomized batches.
        for (int b = 0; b < 12; b++) begin
            run_batch(8'($urandom), 8'($urandom), 8'($urandom_range(0, 6)),
                      int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/max_abs_scan_ctrl.md
# max_abs_scan_ctrl

Sequencer that runs a batch of operand triples through the combinational `maxAbsValueCir` datapath. It fetches packed 12-bit vectors from a vector memory over a valid-qualified read port and drives `w1`/`w2`/`w3` into the datapath. It registers the 4-bit result, writes it to a result memory, and tracks the batch peak. It sits between the vector store (`memModule`-style, 12-bit words) and the datapath, replacing bench-driven stimulus with a self-contained hardware run.

## Interface
- `ADDR_W`, 8: width of vector and result addresses, and of `count`.
- `TIMEOUT`, 16: maximum wait cycles for read data. Used only with `MAXABS_CTRL_TIMEOUT_EN`.
- `clk` in 1: single clock. All logic is on the rising edge.
- `global_reset` in 1: synchronous, active-high reset.
- `start` in 1: begins a batch. Sampled only in IDLE.
- `vec_base` in ADDR_W: first vector address.
- `res_base` in ADDR_W: first result address.
- `count` in ADDR_W: number of vectors in the batch. 0 is legal.
- `mem_rd_en` out 1: one-cycle read request.
- `mem_addr` out ADDR_W: read address.
- `mem_rd_data` in 12: packed vector. `[3:0]`=w1, `[7:4]`=w2, `[11:8]`=w3.
- `mem_rd_valid` in 1: read data valid. Latency is 1 or more cycles.
- `dp_w1`, `dp_w2`, `dp_w3` out 4 each: registered datapath operands.
- `dp_out` in 4: datapath result, combinational from `dp_w*`.
- `res_wr_en` out 1: one-cycle result write strobe (MW).
- `res_addr` out ADDR_W: result write address.
- `res_data` out 4: result write data.
- `peak` out 4: largest `dp_out` in the current batch, compared unsigned.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at batch end.
- `err` out 1: timeout flag. Tied to 0 without the macro.

## Operation
- States are IDLE → FETCH → WAIT → EXEC → WRITE → (FETCH | FIN) → IDLE.
- **IDLE:** on `start`, latch `vec_base`, `res_base` and `count`. Clear the index, `peak` and `err`.
  - If `count`=0, go to FIN.
  - Otherwise go to FETCH.
- **FETCH:** assert `mem_rd_en` for exactly one cycle with `mem_addr` = `vec_base` + idx, then go to WAIT.
- **WAIT:** hold until `mem_rd_valid`. On valid, load `dp_w1`/`dp_w2`/`dp_w3` from `mem_rd_data` and go to EXEC.
- **EXEC:** `dp_out` has settled.
  - Register `res_data` ← `dp_out`.
  - Update `peak` ← max(`peak`, `dp_out`).
  - Go to WRITE.
- **WRITE:** assert `res_wr_en` with `res_addr` = `res_base` + idx, then increment idx.
  - If idx+1 = `count`, go to FIN.
  - Otherwise go to FETCH.
- **FIN:** pulse `done`, drop `busy`, return to IDLE.
  - `peak`, `res_data` and `dp_w*` hold until the next accepted `start`.
- Address arithmetic wraps modulo 2^ADDR_W, with no error raised.
- `start` while `busy` is ignored.
- `mem_rd_valid` outside WAIT is ignored and its data is discarded.
- `global_reset` at any point, including mid-batch, returns to IDLE within that clock. No further `res_wr_en` is issued.
- Reset values: every output is 0.

## Timing
- `busy` rises 1 cycle after the `start` sample.
- Per-vector cost is 3 + L cycles, where L = read latency ≥ 1: FETCH 1, WAIT L, EXEC 1, WRITE 1.
- Batch of N vectors: `done` occurs (3+L)·N + 2 cycles after the `start` sample.
- `count`=0: `done` occurs 2 cycles after `start`, with no reads and no writes.
- `mem_rd_en` and `res_wr_en` are never high in the same cycle, and are never high outside FETCH and WRITE respectively.
- `res_data` and `res_addr` are stable in the `res_wr_en` cycle.

## Configuration
- **`MAXABS_CTRL_TIMEOUT_EN` defined:** a wait counter runs in WAIT.
  - If `mem_rd_valid` is absent for `TIMEOUT` cycles, set `err`=1, skip the write, and go to FIN.
  - `done` still pulses.
  - `err` stays set until the next accepted `start` or reset.
- **Not defined:** WAIT blocks indefinitely and `err` is constant 0.

## Test plan
- **Reset:** assert `global_reset` for 2 cycles → all outputs 0, state IDLE. Then `start` with `count`=0 → `done` 2 cycles later, no `mem_rd_en`.
- **Single vector:** `count`=1, `vec_base`=0x10, L=1, word 12'h3F2 → `mem_addr`=0x10, `dp_w1`=2, `dp_w2`=F, `dp_w3`=3. One write with `res_data`=`dp_out` (3 with `maxAbsValueCir`) at `res_base`. `done` 6 cycles after `start`.
- **Batch peak and wrap:** `count`=4, `vec_base`=0xFE, L=3 → reads at FE, FF, 00, 01. Four writes. `peak` equals the max of the written results. `done` at cycle 26.
- **Ignored inputs:** `start` pulsed while busy → no restart, count unchanged. Spurious `mem_rd_valid` in EXEC → no effect.
- **Mid-batch reset:** `global_reset` during the 2nd WAIT → next cycle IDLE, all outputs 0, no further writes.
- **Timeout (macro on, `TIMEOUT`=4):** `mem_rd_valid` withheld → `err`=1 and `done` pulse 4 cycles into WAIT, no `res_wr_en`. With the macro off, the same stimulus keeps `busy`=1 indefinitely.
